mips_multicycle_ctrl: RTL

//  Multi-cycle control FSM for the 16-bit MIPS datapath. It sequences fetch, decode, execute, memory and write-back.

---
 rtl/mips_multicycle_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Multi-cycle control FSM for the 16-bit MIPS datapath. It sequences
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives every datapath
// strobe and select from the current state, the held instruction word and
// the ALU zero flag. The output names match the datapath control inputs 1:1.
//
// Optional feature macro: CTRL_SINGLE_STEP_EN
//   When defined, a `step` input is added. After each retired instruction
//   the FSM parks in STEP_WAIT and returns to FETCH on the first cycle with
//   step=1. When undefined, there is no `step` port and a retired
//   instruction goes straight back to FETCH.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset; also forces all outputs to 0
//   instruction  instruction word, held stable while InsRead=0
//   zero_flag    ALU zero flag, used by BEQ/BNE in EXEC
//   step         single-step advance (CTRL_SINGLE_STEP_EN only)
//   InsRead      instruction memory read strobe
//   PCnext       PC load enable
//   PCSrc        00 pc+2, 01 branch, 10 jump, 11 rs
//   RegDst       00 rt, 01 rd, 10 r7
//   MemtoReg     00 ALU, 01 mem, 10 pc, 11 in_port
//   ALUControl   000 ADD 001 SUB 010 AND 011 OR 100 XOR 101 SLT 110 SLL 111 SRL
//   ALUSrc       1 selects sign-extended imm[5:0] as ALU operand B
//   MemRead      data memory read strobe
//   MemWrite     data memory write strobe
//   RegWrite     register file write enable
//   outEn        load out_port from rs
//   instr_done   one-cycle pulse in the last cycle of each retired instruction
//   halted       high while in HALT
//   illegal_op   sticky flag, set by an undefined opcode
//   state_o      current state, for debug
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int BUS_WIDTH = 16,
    parameter int OPC_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] instruction,
    input  logic                 zero_flag,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                 step,
`endif
    output logic                 InsRead,
    output logic                 PCnext,
    output logic [1:0]           PCSrc,
    output logic [1:0]           RegDst,
    output logic [1:0]           MemtoReg,
    output logic [2:0]           ALUControl,
    output logic                 ALUSrc,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 outEn,
    output logic                 instr_done,
    output logic                 halted,
    output logic                 illegal_op,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXEC      = 3'd2,
        S_MEM       = 3'd3,
        S_WB        = 3'd4,
        S_HALT      = 3'd5,
        S_STEP_WAIT = 3'd6
    } state_t;

    localparam logic [OPC_WIDTH-1:0] OP_RTYPE = OPC_WIDTH'(0);
    localparam logic [OPC_WIDTH-1:0] OP_ADDI  = OPC_WIDTH'(1);
    localparam logic [OPC_WIDTH-1:0] OP_LW    = OPC_WIDTH'(2);
    localparam logic [OPC_WIDTH-1:0] OP_SW    = OPC_WIDTH'(3);
    localparam logic [OPC_WIDTH-1:0] OP_BEQ   = OPC_WIDTH'(4);
    localparam logic [OPC_WIDTH-1:0] OP_BNE   = OPC_WIDTH'(5);
    localparam logic [OPC_WIDTH-1:0] OP_J     = OPC_WIDTH'(6);
    localparam logic [OPC_WIDTH-1:0] OP_JAL   = OPC_WIDTH'(7);
    localparam logic [OPC_WIDTH-1:0] OP_JR    = OPC_WIDTH'(8);
    localparam logic [OPC_WIDTH-1:0] OP_IN    = OPC_WIDTH'(9);
    localparam logic [OPC_WIDTH-1:0] OP_OUT   = OPC_WIDTH'(10);
    localparam logic [OPC_WIDTH-1:0] OP_HALT  = OPC_WIDTH'(15);

    localparam logic [1:0] PCSRC_PC2    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_R7 = 2'b10;

    localparam logic [1:0] WBSEL_ALU  = 2'b00;
    localparam logic [1:0] WBSEL_MEM  = 2'b01;
    localparam logic [1:0] WBSEL_PC   = 2'b10;
    localparam logic [1:0] WBSEL_PORT = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // Where a retired instruction goes next.
`ifdef CTRL_SINGLE_STEP_EN
    localparam state_t DONE_NEXT = S_STEP_WAIT;
`else
    localparam state_t DONE_NEXT = S_FETCH;
`endif

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   retire;

    logic [OPC_WIDTH-1:0] opcode;
    logic [2:0]           funct;
    logic                 unused_instr_bits;

    assign opcode = instruction[BUS_WIDTH-1 -: OPC_WIDTH];
    assign funct  = instruction[2:0];
    // Register/immediate fields are consumed by the datapath, not here.
    assign unused_instr_bits = ^instruction[BUS_WIDTH-OPC_WIDTH-1:3];

    always_comb begin
        state_d    = S_FETCH;
        illegal_d  = illegal_q;
        retire     = 1'b0;
        InsRead    = 1'b0;
        PCnext     = 1'b0;
        PCSrc      = PCSRC_PC2;
        RegDst     = REGDST_RT;
        MemtoReg   = WBSEL_ALU;
        ALUControl = ALU_ADD;
        ALUSrc     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        outEn      = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_FETCH: begin
                // Memory samples the old PC while the PC loads pc+2.
                InsRead = 1'b1;
                PCnext  = 1'b1;
                PCSrc   = PCSRC_PC2;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = (opcode == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        ALUControl = funct;
                        state_d    = S_WB;
                    end
                    OP_ADDI: begin
                        ALUSrc  = 1'b1;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        ALUSrc  = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        ALUControl = ALU_SUB;
                        PCSrc      = PCSRC_BRANCH;
                        PCnext     = (opcode == OP_BEQ) ? zero_flag : ~zero_flag;
                        retire     = 1'b1;
                    end
                    OP_J: begin
                        PCSrc  = PCSRC_JUMP;
                        PCnext = 1'b1;
                        retire = 1'b1;
                    end
                    OP_JAL: begin
                        // Link write and jump share the cycle; the register
                        // file captures pc+2 before the PC is overwritten.
                        PCSrc    = PCSRC_JUMP;
                        PCnext   = 1'b1;
                        RegDst   = REGDST_R7;
                        MemtoReg = WBSEL_PC;
                        RegWrite = 1'b1;
                        retire   = 1'b1;
                    end
                    OP_JR: begin
                        PCSrc  = PCSRC_RS;
                        PCnext = 1'b1;
                        retire = 1'b1;
                    end
                    OP_IN: begin
                        RegDst   = REGDST_RT;
                        MemtoReg = WBSEL_PORT;
                        RegWrite = 1'b1;
                        retire   = 1'b1;
                    end
                    OP_OUT: begin
                        outEn  = 1'b1;
                        retire = 1'b1;
                    end
                    default: begin
                        // Undefined opcode executes as a NOP and flags itself.
                        illegal_d = 1'b1;
                        retire    = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                // Keep the address computation stable across the access.
                ALUSrc     = 1'b1;
                ALUControl = ALU_ADD;
                if (opcode == OP_LW) begin
                    MemRead = 1'b1;
                    state_d = S_WB;
                end else begin
                    MemWrite = (opcode == OP_SW);
                    retire   = 1'b1;
                end
            end
            S_WB: begin
                retire = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        ALUControl = funct;
                        RegDst     = REGDST_RD;
                        MemtoReg   = WBSEL_ALU;
                        RegWrite   = 1'b1;
                    end
                    OP_ADDI: begin
                        ALUSrc   = 1'b1;
                        RegDst   = REGDST_RT;
                        MemtoReg = WBSEL_ALU;
                        RegWrite = 1'b1;
                    end
                    OP_LW: begin
                        ALUSrc   = 1'b1;
                        RegDst   = REGDST_RT;
                        MemtoReg = WBSEL_MEM;
                        RegWrite = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            S_STEP_WAIT: begin
`ifdef CTRL_SINGLE_STEP_EN
                state_d = step ? S_FETCH : S_STEP_WAIT;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase

        if (retire) begin
            instr_done = 1'b1;
            state_d    = DONE_NEXT;
        end

        illegal_op = illegal_q;
        state_o    = state_q;

        // Reset gates every output in the same cycle so an in-flight
        // register or memory write cannot complete.
        if (rst) begin
            InsRead    = 1'b0;
            PCnext     = 1'b0;
            PCSrc      = 2'b00;
            RegDst     = 2'b00;
            MemtoReg   = 2'b00;
            ALUControl = 3'b000;
            ALUSrc     = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            outEn      = 1'b0;
            instr_done = 1'b0;
            halted     = 1'b0;
            illegal_op = 1'b0;
            state_o    = 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

endmodule
